// File: rtl/spw_token_trace_logger_if.sv
// Trace-logger bus: detector word and arm/trigger controls in, drain port and status out.
interface spw_token_trace_logger_if #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TS_WIDTH   = 16
);
    logic [13:0]              info;
    logic                     arm;
    logic [5:0]               trig_mask;
    logic                     rd_en;
    logic [TS_WIDTH+13:0]     rd_data;
    logic                     rd_valid;
    logic [1:0]               state;
    logic                     triggered;
    logic [DEPTH_LOG2:0]      entry_count;
    logic                     overflow;
    logic [7:0]               err_count;

    modport master (
        output info, arm, trig_mask, rd_en,
        input  rd_data, rd_valid, state, triggered, entry_count, overflow, err_count
    );

    modport slave (
        input  info, arm, trig_mask, rd_en,
        output rd_data, rd_valid, state, triggered, entry_count, overflow, err_count
    );
endinterface

// File: rtl/spw_token_trace_logger.sv
// Pre/post-trigger trace buffer for receive-side token detector changes,
// with timestamps and a saturating rx_error edge counter.
module spw_token_trace_logger #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned POST_TRIG  = 8
) (
    input  logic                    posedge_clk,
    input  logic                    rx_resetn,
    spw_token_trace_logger_if.slave bus
);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned INFO_W  = 14;
    localparam int unsigned ENTRY_W = TS_WIDTH + INFO_W;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [INFO_W-1:0]     r_info_q;
    logic                  r_arm_q;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [DEPTH_LOG2-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [CNT_W-1:0]      r_count, w_count_nxt;
    logic [DEPTH_LOG2-1:0] r_post, w_post_nxt;
    logic                  r_triggered, w_triggered_nxt;
    logic                  r_overflow, w_overflow_nxt;
    logic [7:0]            r_err, w_err_nxt;
    logic [ENTRY_W-1:0]    r_rd_data, w_rd_data_nxt;
    logic                  r_rd_valid, w_rd_valid_nxt;
    logic [ENTRY_W-1:0]    r_mem [DEPTH];

    logic               w_change, w_arm_rise, w_err_rise, w_full, w_match, w_wr_en;
    logic [ENTRY_W-1:0] w_entry;

    assign w_change   = (bus.info != r_info_q);
    assign w_arm_rise = bus.arm & ~r_arm_q;
    assign w_err_rise = bus.info[5] & ~r_info_q[5];
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_match    = |(bus.info[5:0] & bus.trig_mask);
    assign w_entry    = {r_ts, bus.info};

    // Capture control, buffer bookkeeping and next show-ahead head entry.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_count_nxt     = r_count;
        w_post_nxt      = r_post;
        w_triggered_nxt = r_triggered;
        w_overflow_nxt  = r_overflow;
        w_err_nxt       = r_err;
        w_wr_en         = 1'b0;
        w_rd_data_nxt   = '0;
        w_rd_valid_nxt  = 1'b0;

        if (w_err_rise && (r_err != 8'hFF)) begin
            w_err_nxt = r_err + 8'd1;
        end

        if (w_arm_rise) begin
            w_state_nxt     = ST_ARMED;
            w_wr_ptr_nxt    = '0;
            w_rd_ptr_nxt    = '0;
            w_count_nxt     = '0;
            w_post_nxt      = '0;
            w_triggered_nxt = 1'b0;
            w_overflow_nxt  = 1'b0;
            w_err_nxt       = '0;
        end else begin
            case (r_state)
                ST_ARMED, ST_TRIGGERED: begin
                    if (w_change) begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + DEPTH_LOG2'(1);
                        // Full buffer behaves as a ring: drop the oldest entry.
                        if (w_full) begin
                            w_rd_ptr_nxt   = r_rd_ptr + DEPTH_LOG2'(1);
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                        if (r_state == ST_ARMED) begin
                            if (w_match) begin
                                w_triggered_nxt = 1'b1;
                                w_post_nxt      = DEPTH_LOG2'(POST_TRIG);
                                w_state_nxt     = (POST_TRIG == 0) ? ST_DONE : ST_TRIGGERED;
                            end
                        end else begin
                            w_post_nxt = r_post - DEPTH_LOG2'(1);
                            if (r_post == DEPTH_LOG2'(1)) begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rd_en && r_rd_valid) begin
                        w_rd_ptr_nxt = r_rd_ptr + DEPTH_LOG2'(1);
                        w_count_nxt  = r_count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Bypass the entry being written when it becomes the head in the same cycle.
        if (w_state_nxt == ST_DONE) begin
            w_rd_valid_nxt = (w_count_nxt != '0);
            w_rd_data_nxt  = (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) ? w_entry : r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge posedge_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            r_state     <= ST_IDLE;
            r_info_q    <= '0;
            r_arm_q     <= 1'b0;
            r_ts        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post      <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_info_q    <= bus.info;
            r_arm_q     <= bus.arm;
            r_ts        <= r_ts + TS_WIDTH'(1);
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_post      <= w_post_nxt;
            r_triggered <= w_triggered_nxt;
            r_overflow  <= w_overflow_nxt;
            r_err       <= w_err_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
        end
    end

    // Trace storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge posedge_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign bus.state       = r_state;
    assign bus.triggered   = r_triggered;
    assign bus.entry_count = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.err_count   = r_err;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
endmodule

// File: tb/tb_spw_token_trace_logger.sv
// Bench for spw_token_trace_logger: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_spw_token_trace_logger;
    localparam int unsigned DL2 = 4;
    localparam int unsigned TSW = 16;
    localparam int          P0  = 8;
    localparam int          DEPTH = 16;

    logic posedge_clk = 1'b0;
    logic rx_resetn   = 1'b0;

    spw_token_trace_logger_if #(.DEPTH_LOG2(DL2), .TS_WIDTH(TSW)) bus0 ();
    spw_token_trace_logger_if #(.DEPTH_LOG2(DL2), .TS_WIDTH(TSW)) bus1 ();

    spw_token_trace_logger #(.DEPTH_LOG2(DL2), .TS_WIDTH(TSW), .POST_TRIG(P0)) dut0 (
        .posedge_clk(posedge_clk), .rx_resetn(rx_resetn), .bus(bus0.slave));
    spw_token_trace_logger #(.DEPTH_LOG2(DL2), .TS_WIDTH(TSW), .POST_TRIG(0)) dut1 (
        .posedge_clk(posedge_clk), .rx_resetn(rx_resetn), .bus(bus1.slave));

    always #5 posedge_clk = ~posedge_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: entries kept in a queue, oldest first.
    logic [29:0] m_q[$];
    int          m_state, m_post, m_err;
    bit          m_trig, m_ovf, m_arm_q;
    logic [13:0] m_info_q;
    logic [15:0] m_ts;

    task automatic model_reset();
        m_q.delete();
        m_state = 0; m_post = 0; m_err = 0;
        m_trig = 0; m_ovf = 0; m_arm_q = 0;
        m_info_q = '0; m_ts = '0;
    endtask

    task automatic model_step();
        logic [13:0] inf;
        bit chg, arm_rise, err_rise;
        inf      = bus0.info;
        chg      = (inf != m_info_q);
        arm_rise = bus0.arm && !m_arm_q;
        err_rise = inf[5] && !m_info_q[5];
        if (err_rise && m_err < 255) m_err++;
        if (arm_rise) begin
            m_state = 1; m_q.delete(); m_trig = 0; m_ovf = 0; m_err = 0; m_post = 0;
        end else if ((m_state == 1 || m_state == 2) && chg) begin
            if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1;
            end
            m_q.push_back({m_ts, inf});
            if (m_state == 1) begin
                if ((inf[5:0] & bus0.trig_mask) != 0) begin
                    m_trig = 1; m_post = P0;
                    m_state = (P0 == 0) ? 3 : 2;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end else if (m_state == 3 && bus0.rd_en && m_q.size() > 0) begin
            void'(m_q.pop_front());
        end
        m_info_q = inf;
        m_arm_q  = bus0.arm;
        m_ts     = m_ts + 16'd1;
    endtask

    task automatic check_model();
        bit vld;
        vld = (m_state == 3) && (m_q.size() > 0);
        chk("m_state", 64'(bus0.state), 64'(m_state));
        chk("m_count", 64'(bus0.entry_count), 64'(m_q.size()));
        chk("m_trig", 64'(bus0.triggered), 64'(m_trig));
        chk("m_ovf", 64'(bus0.overflow), 64'(m_ovf));
        chk("m_err", 64'(bus0.err_count), 64'(m_err));
        chk("m_valid", 64'(bus0.rd_valid), 64'(vld));
        if (vld) chk("m_rd_data", 64'(bus0.rd_data), 64'(m_q[0]));
    endtask

    task automatic tick();
        if (rx_resetn) model_step(); else model_reset();
        @(posedge posedge_clk);
        #1;
    endtask

    typedef struct {
        logic [13:0] info;
        logic        arm;
        logic        rd_en;
        logic [1:0]  st;
        int          cnt;
        logic        trig;
        logic        vld;
        logic [29:0] rdd;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [13:0] info, input logic arm, input logic rd_en,
                       input logic [1:0] st, input int cnt, input logic trig,
                       input logic vld, input logic [29:0] rdd);
        vec_t v;
        v.info = info; v.arm = arm; v.rd_en = rd_en; v.st = st;
        v.cnt = cnt; v.trig = trig; v.vld = vld; v.rdd = rdd;
        tbl.push_back(v);
    endtask

    function automatic logic [29:0] exp_entry(input int k);
        if (k == 0) return {16'd5, 14'h0004};
        if (k == 1) return {16'd9, 14'h0008};
        if (k == 2) return {16'd10, 14'h0020};
        return {16'(8 + k), 14'(32'h40 << (k - 3))};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] head_info;
        bus0.info = '0; bus0.arm = 0; bus0.trig_mask = 6'b100000; bus0.rd_en = 0;
        bus1.info = '0; bus1.arm = 0; bus1.trig_mask = 6'b000001; bus1.rd_en = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge posedge_clk);
        #1;
        chk("rst_state", 64'(bus0.state), 64'd0);
        chk("rst_count", 64'(bus0.entry_count), 64'd0);
        chk("rst_rd_data", 64'(bus0.rd_data), 64'd0);
        chk("rst_valid", 64'(bus0.rd_valid), 64'd0);
        chk("rst_err", 64'(bus0.err_count), 64'd0);
        rx_resetn = 1'b1;

        // Directed capture: two pre-trigger entries, trigger, 8 post, drain 11
        add(14'h0, 1, 0, 2'd1, 0, 0, 0, '0);
        repeat (4) add(14'h0, 0, 0, 2'd1, 0, 0, 0, '0);
        repeat (4) add(14'h0004, 0, 0, 2'd1, 1, 0, 0, '0);
        add(14'h0008, 0, 0, 2'd1, 2, 0, 0, '0);
        add(14'h0020, 0, 0, 2'd2, 3, 1, 0, '0);
        for (int j = 0; j < 8; j++)
            add(14'(32'h40 << j), 0, 0, (j == 7) ? 2'd3 : 2'd2, 4 + j, 1,
                (j == 7), (j == 7) ? exp_entry(0) : 30'd0);
        for (int k = 1; k <= 11; k++)
            add(14'h2000, 0, 1, 2'd3, 11 - k, 1, (k < 11), (k < 11) ? exp_entry(k) : 30'd0);
        add(14'h2000, 0, 1, 2'd3, 0, 1, 0, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus0.info = tbl[i].info; bus0.arm = tbl[i].arm; bus0.rd_en = tbl[i].rd_en;
            tick();
            chk($sformatf("tbl%0d_state", i), 64'(bus0.state), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_count", i), 64'(bus0.entry_count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_trig", i), 64'(bus0.triggered), 64'(tbl[i].trig));
            chk($sformatf("tbl%0d_valid", i), 64'(bus0.rd_valid), 64'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_rd_data", i), 64'(bus0.rd_data), 64'(tbl[i].rdd));
            check_model();
        end
        bus0.rd_en = 0;

        // Overflow: 20 non-trigger changes, then trigger and 8 post writes
        bus0.trig_mask = 6'b000001;
        bus0.arm = 1; tick(); check_model();
        bus0.arm = 0;
        for (int i = 0; i < 20; i++) begin
            bus0.info = 14'((i + 1) << 6); tick(); check_model();
        end
        chk("ovf_count", 64'(bus0.entry_count), 64'd16);
        chk("ovf_flag", 64'(bus0.overflow), 64'd1);
        chk("ovf_state", 64'(bus0.state), 64'd1);
        bus0.info = 14'h0001; tick(); check_model();
        chk("ovf_trig_state", 64'(bus0.state), 64'd2);
        for (int i = 0; i < 8; i++) begin
            bus0.info = 14'((21 + i) << 6); tick(); check_model();
        end
        head_info = bus0.rd_data[13:0];
        chk("ovf_done", 64'(bus0.state), 64'd3);
        chk("ovf_head", 64'(head_info), 64'(14 << 6));

        // POST_TRIG=0 instance: done right after the trigger write
        bus1.arm = 1; tick(); check_model();
        chk("p0_armed", 64'(bus1.state), 64'd1);
        bus1.arm = 0; bus1.info = 14'h0001; tick(); check_model();
        chk("p0_state", 64'(bus1.state), 64'd3);
        chk("p0_count", 64'(bus1.entry_count), 64'd1);
        chk("p0_valid", 64'(bus1.rd_valid), 64'd1);
        chk("p0_info", 64'(bus1.rd_data[13:0]), 64'h0001);
        bus1.rd_en = 1; tick(); check_model();
        chk("p0_pop_count", 64'(bus1.entry_count), 64'd0);
        chk("p0_pop_valid", 64'(bus1.rd_valid), 64'd0);
        bus1.rd_en = 0;

        // Error counter saturation, then arm coincident with an error edge
        bus0.trig_mask = 6'b000000;
        for (int i = 0; i < 600; i++) begin
            bus0.info = (i % 2 == 0) ? 14'h0020 : 14'h0000; tick(); check_model();
        end
        chk("err_sat", 64'(bus0.err_count), 64'd255);
        bus0.arm = 1; bus0.info = 14'h0020; tick(); check_model();
        chk("arm_err_clear", 64'(bus0.err_count), 64'd0);
        chk("arm_no_write", 64'(bus0.entry_count), 64'd0);
        bus0.arm = 0; tick(); check_model();
        chk("arm_hold_count", 64'(bus0.entry_count), 64'd0);

        // Reset asserted while TRIGGERED
        bus0.trig_mask = 6'b100000;
        bus0.info = 14'h0000; tick(); check_model();
        bus0.info = 14'h0020; tick(); check_model();
        chk("pre_rst_state", 64'(bus0.state), 64'd2);
        rx_resetn = 1'b0;
        #1;
        chk("mid_rst_state", 64'(bus0.state), 64'd0);
        chk("mid_rst_count", 64'(bus0.entry_count), 64'd0);
        chk("mid_rst_trig", 64'(bus0.triggered), 64'd0);
        chk("mid_rst_rd_data", 64'(bus0.rd_data), 64'd0);
        model_reset();
        bus0.info = '0; bus0.arm = 0;
        tick(); tick();
        rx_resetn = 1'b1;
        bus0.arm = 1; tick(); check_model();
        bus0.arm = 0; tick(); check_model();
        bus0.info = 14'h0020; tick(); check_model();
        for (int j = 0; j < 8; j++) begin
            bus0.info = 14'(32'h40 << j); tick(); check_model();
        end
        chk("ts_restart_head", 64'(bus0.rd_data), 64'({16'd2, 14'h0020}));

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) bus0.info = 14'($urandom);
            bus0.arm   = ($urandom_range(0, 99) < 2);
            bus0.rd_en = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 49) == 0) bus0.trig_mask = 6'(1 << $urandom_range(0, 5));
            tick();
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
